// File: rtl/game_ctrl_pkg.sv
// Shared game-flow encodings and geometry constants, common to the pipe
// generator, the renderer and the game controller.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int COORD_W     = 12;
  localparam int NUM_PIPES   = 2;

  localparam int SCREEN_W    = 1024;
  localparam int SCREEN_H    = 768;
  localparam int BIRD_X      = 300;
  localparam int BIRD_W      = 34;
  localparam int BIRD_H      = 24;
  localparam int PIPE_W      = 80;
  localparam int PIPE_GAP_H  = 200;
  localparam int FLOOR_Y     = 768;
  localparam int LOCK_FRAMES = 30;

  // One pipe as seen by the collision logic
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] gap_y;
  } pipe_t;

endpackage

// File: rtl/game_ctrl_bcd_cnt3.sv
// Three-digit packed-BCD counter: synchronous clear, increment with digit
// carry, holds at 999. q_inc exposes the would-be next value so callers can
// act on an increment in the same cycle it is applied.
module bcd_cnt3 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [11:0] q,
  output logic [11:0] q_inc
);

  // Saturating BCD increment of the current value
  always_comb begin
    q_inc = q;
    if (q != 12'h999) begin
      if (q[3:0] != 4'd9) begin
        q_inc[3:0] = q[3:0] + 4'd1;
      end else begin
        q_inc[3:0] = 4'd0;
        if (q[7:4] != 4'd9) begin
          q_inc[7:4] = q[7:4] + 4'd1;
        end else begin
          q_inc[7:4]  = 4'd0;
          q_inc[11:8] = q[11:8] + 4'd1;
        end
      end
    end
  end

  // Count register; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= q_inc;
  end

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: button edge detect, per-frame bird/pipe/floor
// collision, IDLE/PLAY/OVER sequencing, current and best BCD scores.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int BIRD_X_P      = BIRD_X,
  parameter int BIRD_W_P      = BIRD_W,
  parameter int BIRD_H_P      = BIRD_H,
  parameter int PIPE_W_P      = PIPE_W,
  parameter int PIPE_GAP_H_P  = PIPE_GAP_H,
  parameter int FLOOR_Y_P     = FLOOR_Y,
  parameter int LOCK_FRAMES_P = LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_en,
  input  logic        btn_flap,
  input  logic [11:0] bird_y,
  input  logic [11:0] pipe1_x,
  input  logic [11:0] pipe1_gap_y,
  input  logic [11:0] pipe2_x,
  input  logic [11:0] pipe2_gap_y,
  input  logic        score_pulse,
  output logic        game_active,
  output logic        game_over,
  output logic [1:0]  state,
  output logic        hit,
  output logic [11:0] score_bcd,
  output logic [11:0] best_bcd
);

  localparam int          LOCK_W = $clog2(LOCK_FRAMES_P + 1);
  // All geometry arithmetic is carried at 13 bits so sums never wrap
  localparam logic [12:0] BX     = 13'(BIRD_X_P);
  localparam logic [12:0] BX_R   = 13'(BIRD_X_P + BIRD_W_P);
  localparam logic [12:0] BH     = 13'(BIRD_H_P);
  localparam logic [12:0] PW     = 13'(PIPE_W_P);
  localparam logic [12:0] HALF   = 13'(PIPE_GAP_H_P / 2);
  localparam logic [12:0] FLOOR  = 13'(FLOOR_Y_P);

  state_t             st;
  logic [LOCK_W-1:0]  lock_cnt;
  logic               sync1, sync2, btn_dly;
  logic               btn_rise;
  logic               go_play;
  logic               coll;
  logic               score_inc;
  logic [11:0]        score_next;
  logic [11:0]        score_q_inc;

  // Button: two-flop synchroniser plus a delay flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      btn_dly <= 1'b0;
    end else begin
      sync1   <= btn_flap;
      sync2   <= sync1;
      btn_dly <= sync2;
    end
  end

  assign btn_rise = sync2 & ~btn_dly;

  // Per-pipe collision; a pipe with x >= 2048 has wrapped off the left edge
  pipe_t [NUM_PIPES-1:0]  pipes;
  logic  [NUM_PIPES-1:0]  pipe_hit;
  logic  [12:0]           by, by_bot;

  assign pipes[0] = '{x: pipe1_x, gap_y: pipe1_gap_y};
  assign pipes[1] = '{x: pipe2_x, gap_y: pipe2_gap_y};
  assign by       = {1'b0, bird_y};
  assign by_bot   = by + BH;

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
    logic [12:0] px, gy, top, bot;
    logic        x_ov, y_out;
    assign px       = {1'b0, pipes[g].x};
    assign gy       = {1'b0, pipes[g].gap_y};
    assign x_ov     = ~pipes[g].x[11] && (px < BX_R) && ((px + PW) > BX);
    assign top      = (gy < HALF) ? 13'd0 : (gy - HALF);
    assign bot      = gy + HALF;
    assign y_out    = (by < top) || (by_bot > bot);
    assign pipe_hit[g] = x_ov & y_out;
  end

  assign coll = (|pipe_hit) || (by_bot > FLOOR) || bird_y[11];

  // Restart is only honoured from IDLE or from OVER once the lockout expires
  assign go_play    = btn_rise && ((st == ST_IDLE) || ((st == ST_OVER) && (lock_cnt == '0)));
  assign score_inc  = score_pulse && (st == ST_PLAY);
  assign score_next = score_inc ? score_q_inc : score_bcd;

  bcd_cnt3 u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go_play),
    .inc   (score_inc),
    .q     (score_bcd),
    .q_inc (score_q_inc)
  );

  // Game state machine with registered flags, lockout and best score
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_IDLE;
      game_active <= 1'b0;
      game_over   <= 1'b0;
      hit         <= 1'b0;
      lock_cnt    <= '0;
      best_bcd    <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (go_play) begin
            st          <= ST_PLAY;
            game_active <= 1'b1;
            hit         <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (frame_en && coll) begin
            st          <= ST_OVER;
            game_active <= 1'b0;
            game_over   <= 1'b1;
            hit         <= 1'b1;
            lock_cnt    <= LOCK_W'(LOCK_FRAMES_P);
            // Packed BCD compares correctly as plain unsigned
            if (score_next > best_bcd) best_bcd <= score_next;
          end
        end
        ST_OVER: begin
          if (go_play) begin
            st          <= ST_PLAY;
            game_active <= 1'b1;
            game_over   <= 1'b0;
            hit         <= 1'b0;
          end else if (frame_en && (lock_cnt != '0)) begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        default: begin
          st          <= ST_IDLE;
          game_active <= 1'b0;
          game_over   <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: scoreboard of expected score/best pushed at each
// crash, popped when the DUT reaches OVER.
module tb_game_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_en = 1'b0, btn_flap = 1'b0, score_pulse = 1'b0;
  logic [11:0] bird_y = 12'd372;
  logic [11:0] pipe1_x = 12'd1000, pipe1_gap_y = 12'd384;
  logic [11:0] pipe2_x = 12'd900,  pipe2_gap_y = 12'd384;
  logic        game_active, game_over, hit;
  logic [1:0]  state;
  logic [11:0] score_bcd, best_bcd;

  int total = 0;
  int bad   = 0;
  logic [11:0] score_m = '0, best_m = '0;
  logic [11:0] sb_score_q[$];
  logic [11:0] sb_best_q[$];

  game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_en(frame_en), .btn_flap(btn_flap),
    .bird_y(bird_y), .pipe1_x(pipe1_x), .pipe1_gap_y(pipe1_gap_y),
    .pipe2_x(pipe2_x), .pipe2_gap_y(pipe2_gap_y), .score_pulse(score_pulse),
    .game_active(game_active), .game_over(game_over), .state(state),
    .hit(hit), .score_bcd(score_bcd), .best_bcd(best_bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    int n;
    n = int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    if (n < 999) n++;
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic int bcd_val(input logic [11:0] v);
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic safe_geom();
    bird_y = 12'd372; pipe1_x = 12'd1000; pipe1_gap_y = 12'd384;
    pipe2_x = 12'd900; pipe2_gap_y = 12'd384;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_en = 1'b1; tick(); frame_en = 1'b0; tick();
    end
  endtask

  // Press and release the button; lat = clocks until PLAY (-1 if never)
  task automatic press(output int lat);
    lat = -1;
    btn_flap = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (state == 2'd1 && lat < 0) lat = i;
    end
    btn_flap = 1'b0;
    repeat (4) tick();
  endtask

  task automatic start(input string tag);
    int lat;
    press(lat);
    chk({tag, "_enter"}, (lat > 0 && lat <= 4), 1);
    chk({tag, "_state"}, state, 1);
    chk({tag, "_active"}, game_active, 1);
    chk({tag, "_score0"}, score_bcd, 12'h000);
    chk({tag, "_hit0"}, hit, 0);
    score_m = '0;
  endtask

  task automatic pulses(input int n);
    score_pulse = 1'b1;
    repeat (n) begin
      tick();
      score_m = bcd_inc(score_m);
    end
    score_pulse = 1'b0;
  endtask

  // Crash into pipe1 (or pipe2), optionally with a score pulse in the same cycle
  task automatic crash(input bit use_p2, input bit with_pulse);
    int n;
    if (use_p2) begin
      pipe2_x = 12'd290; pipe2_gap_y = 12'd384; bird_y = 12'd500;
    end else begin
      pipe1_x = 12'd250; pipe1_gap_y = 12'd384; bird_y = 12'd260;
    end
    if (with_pulse) score_m = bcd_inc(score_m);
    if (bcd_val(score_m) > bcd_val(best_m)) best_m = score_m;
    sb_score_q.push_back(score_m);
    sb_best_q.push_back(best_m);
    frame_en = 1'b1; score_pulse = with_pulse;
    tick();
    frame_en = 1'b0; score_pulse = 1'b0;
    n = 0;
    while (state != 2'd2 && n < 4) begin tick(); n++; end
    chk("crash_over", state, 2);
    chk("crash_hit", hit, 1);
    chk("crash_inactive", game_active, 0);
    chk("crash_gameover", game_over, 1);
    chk("sb_score", score_bcd, sb_score_q.pop_front());
    chk("sb_best", best_bcd, sb_best_q.pop_front());
    safe_geom();
  endtask

  initial begin
    int lat;
    #12;
    chk("rst_state", state, 0);
    chk("rst_active", game_active, 0);
    chk("rst_over", game_over, 0);
    chk("rst_hit", hit, 0);
    chk("rst_score", score_bcd, 0);
    chk("rst_best", best_bcd, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // score_pulse in IDLE is ignored
    pulses(3); score_m = '0;
    chk("idle_pulse", score_bcd, 0);

    // 1/2: start, gap clear, collision between strobes ignored, then crash
    start("t1");
    bird_y = 12'd372; pipe1_x = 12'd250; pipe1_gap_y = 12'd384; pipe2_x = 12'd900;
    frames(1);
    chk("gap_nohit_state", state, 1);
    chk("gap_nohit_hit", hit, 0);
    bird_y = 12'd260;
    repeat (3) tick();
    chk("nostrobe_state", state, 1);
    crash(0, 0);

    // 5: lockout ignores early restart
    frames(10);
    press(lat);
    chk("lock_ignored", state, 2);
    frames(20);
    start("t5");

    // 3: scoring and best tracking
    pulses(12);
    chk("score12", score_bcd, 12'h012);
    crash(0, 0);
    frames(30); start("t3b");
    pulses(5);
    crash(1, 0);
    chk("best_kept", best_bcd, 12'h012);
    // pulse and collision in the same cycle: best sees the increment
    frames(30); start("t3c");
    pulses(12);
    crash(0, 1);
    chk("best13", best_bcd, 12'h013);

    // 4: digit carry and saturation
    frames(30); start("t4");
    pulses(99);
    chk("score099", score_bcd, 12'h099);
    pulses(1);
    chk("score100", score_bcd, 12'h100);
    pulses(899);
    chk("score999", score_bcd, 12'h999);
    pulses(1);
    chk("score_sat", score_bcd, 12'h999);
    crash(0, 0);

    // 6: wrapped pipe never overlaps; floor boundary
    frames(30); start("t6");
    pipe1_x = 12'd4090; pipe1_gap_y = 12'd384; bird_y = 12'd260;
    frames(1);
    chk("wrap_nohit", state, 1);
    bird_y = 12'd744;
    frames(1);
    chk("floor_edge_nohit", state, 1);
    bird_y = 12'd745;
    frames(1);
    chk("floor_hit_state", state, 2);
    chk("floor_hit", hit, 1);
    safe_geom();

    // mid-PLAY reset clears everything at once
    frames(30); start("trst");
    pulses(3);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_state", state, 0);
    chk("mrst_active", game_active, 0);
    chk("mrst_over", game_over, 0);
    chk("mrst_hit", hit, 0);
    chk("mrst_score", score_bcd, 0);
    chk("mrst_best", best_bcd, 0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
